hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard-detection and forwarding controller for the pipelined RISC-V core. It generalises the fixed load-use stall and two-stage forwarding logic to a configurable back-end depth and load latency. It keeps a shift-register scoreboard of in-flight destination registers, stalls the ID stage only when a needed result cannot yet be forwarded, and delivers registered forwarding selects to the EX stage. It sits alongside the IF/ID and ID/EX pipeline registers, and it also absorbs branch flushes from MEM.

## Interface
Parameters:
- DEPTH, 3: back-end stages tracked (1=EX, 2=MEM, …, DEPTH=WB); legal range DEPTH ≥ 2.
- LOAD_LAT, 1: extra stages before load data exists past MEM; legal range 0 ≤ LOAD_LAT ≤ DEPTH-2.
- CNTW, 32: stall-counter width.
- FW, $clog2(DEPTH+1): forward-select width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_use_rs1, id_use_rs2  in  1  instruction reads that source.
- id_rd  in  5  destination index.
- id_regwrite  in  1  instruction writes rd.
- id_memread  in  1  instruction is a load.
- flush  in  1  branch taken, resolved in MEM.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may update.
- idex_bubble  out  1  ID/EX must load zeroed controls.
- fwd_a, fwd_b  out  FW  EX operand source: 0 = register file, k = pipeline latch feeding stage k.
- stall_count  out  CNTW  saturating count of stall cycles.

## Operation
- Scoreboard entry e[k], k = 1..DEPTH, holds {v, rd, wr, ld}.
- Hazard search, per used source rs ≠ 0:
  - Find the smallest k with e[k].v & e[k].wr & e[k].rd == rs (youngest producer).
  - If no entry matches, next select = 0.
  - If a match is found, the producer sits at stage k+1 when the consumer enters EX.
  - If e[k].ld and k ≤ LOAD_LAT, the source is not ready and raises stall.
  - Otherwise next select = k+1, or 0 if k+1 > DEPTH.
  - Sources with use=0 or rs=0 never stall and select 0.
- stall = id_valid & ~flush & (hazard on rs1 | hazard on rs2). This is combinational.
- pc_write = ifid_write = ~stall; idex_bubble = stall | flush | ~id_valid.
- Each clk edge:
  - Shift e[k+1] ← e[k] for k < DEPTH; the e[DEPTH] contents retire.
  - If idex_bubble, e[1] ← invalid.
  - Otherwise e[1] ← {1, id_rd, id_regwrite & (id_rd≠0), id_memread}.
- fwd_a/fwd_b update on the same edge:
  - Next selects when e[1] receives an instruction.
  - 0 on any bubble.
- Flush has priority over stall. The ID instruction is discarded and e[1] (the wrong-path instruction in EX) is not carried forward as valid into e[2].
- stall_count increments on every cycle with stall=1 and holds at 2^CNTW-1.
- The register file must be write-first, because a consumer read in ID while its producer is in WB gets select 0.

## Timing
- Reset (reset=0, asynchronous) sets:
  - all e[k].v = 0
  - fwd_a = fwd_b = 0
  - stall_count = 0
- Consequently, during reset pc_write = ifid_write = 1, and idex_bubble follows id_valid/flush.
- stall responds combinationally in the same cycle; scoreboard and selects have one-edge latency.
- A load-use with LOAD_LAT=L costs L - k + 1 stall cycles for a producer found at k ≤ L. Each stall cycle re-evaluates the search against the shifted scoreboard.
- Back-to-back ALU dependency: zero stalls, select 2.
- Reset asserted mid-stall: stall drops immediately and scoreboard entries clear.

## Test plan
- DEPTH=3, LOAD_LAT=1. Stimulus: ld x5 then add x6,x5,x7. Required: 1 cycle with stall=1, pc_write=0, idex_bubble=1; the add then enters EX with fwd_a=3, fwd_b=0.
- Stimulus: add x1 then sub x2,x1,x1. Required: no stall; fwd_a=fwd_b=2. Stimulus: producer followed by two unrelated instructions, then the consumer. Required: select 0.
- LOAD_LAT=2, DEPTH=4. Stimulus: ld x3 then use x3. Required: exactly 2 stall cycles, then fwd=4.
- Stimulus: flush=1 while a load-use stall is pending. Required: stall=0 and idex_bubble=1 that cycle; the next cycle e[2].v=0 and fwd=0.
- Stimulus: writes to x0 (ld x0 then use x0), and id_use_rs2=0 with a matching rs2. Required: never stall, selects 0.
- CNTW=3. Stimulus: 9 stall cycles. Required: stall_count saturates at 7. Stimulus: reset pulse mid-stall. Required: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard detection and forwarding control for a back-end of DEPTH stages
//   (1 = EX .. DEPTH = WB) with a load result that appears LOAD_LAT stages
//   after MEM. A shift-register scoreboard tracks in-flight destinations.
//   ID is stalled only when a needed load result cannot be forwarded yet.
//   Forwarding selects are registered so that they line up with the
//   instruction as it enters EX.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   id_*              decoded fields of the instruction currently in ID
//   flush             taken branch resolved in MEM; kills ID and EX
//   pc_write          PC may update
//   ifid_write        IF/ID register may update
//   idex_bubble       ID/EX register loads zeroed controls
//   fwd_a, fwd_b      EX operand source: 0 = regfile, k = latch feeding stage k
//   stall_count       saturating count of stall cycles
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 32,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            flush,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_bubble,
    output logic [FW-1:0]   fwd_a,
    output logic [FW-1:0]   fwd_b,
    output logic [CNTW-1:0] stall_count
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } entry_t;

    typedef entry_t [DEPTH:1] sb_t;

    sb_t           e_q, e_d;
    logic [FW-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic          haz_a, haz_b, stall;
    logic [FW-1:0] sel_a, sel_b;

    // Returns {hazard, select}. Scanning from the oldest stage down to EX
    // leaves the youngest matching producer as the final winner.
    function automatic logic [FW:0] search(input sb_t e, input logic [4:0] rs,
                                           input logic use_rs);
        logic          haz;
        logic [FW-1:0] sel;
        haz = 1'b0;
        sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (e[k].v && e[k].wr && (e[k].rd == rs)) begin
                haz = e[k].ld && (k <= LOAD_LAT);
                // Producer in WB when the consumer reaches EX: the write-first
                // register file already supplies the value.
                sel = (k + 1 > DEPTH) ? '0 : FW'(k + 1);
            end
        end
        if (!use_rs || (rs == 5'd0)) begin
            haz = 1'b0;
            sel = '0;
        end
        return {haz, sel};
    endfunction

    always_comb begin
        {haz_a, sel_a} = search(e_q, id_rs1, id_use_rs1);
        {haz_b, sel_b} = search(e_q, id_rs2, id_use_rs2);
        stall       = id_valid && !flush && (haz_a || haz_b);
        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall || flush || !id_valid;
    end

    always_comb begin
        for (int k = DEPTH; k >= 2; k--) begin
            e_d[k] = e_q[k-1];
        end
        // The instruction in EX is on the wrong path when MEM flushes.
        if (flush) begin
            e_d[2].v = 1'b0;
        end
        e_d[1] = '0;
        if (!idex_bubble) begin
            e_d[1].v  = 1'b1;
            e_d[1].rd = id_rd;
            e_d[1].wr = id_regwrite && (id_rd != 5'd0);
            e_d[1].ld = id_memread;
        end

        fwd_a_d = idex_bubble ? '0 : sel_a;
        fwd_b_d = idex_bubble ? '0 : sel_b;

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q     <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
    } in_t;

    typedef struct {
        int   d;     // 0: DEPTH=3/LOAD_LAT=1 unit, 1: DEPTH=4/LOAD_LAT=2 unit
        in_t  in;
        logic st;
        logic bub;
        int   fa;
        int   fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  in3, in4;

    logic       pcw3, ifw3, bub3;
    logic [1:0] fa3, fb3;
    logic [2:0] cnt3;
    logic       pcw4, ifw4, bub4;
    logic [2:0] fa4, fb4;
    logic [7:0] cnt4;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .CNTW(3)) dut3 (
        .clk(clk), .reset(rst_n), .id_valid(in3.valid),
        .id_rs1(in3.rs1), .id_rs2(in3.rs2),
        .id_use_rs1(in3.u1), .id_use_rs2(in3.u2),
        .id_rd(in3.rd), .id_regwrite(in3.rw), .id_memread(in3.mr),
        .flush(in3.fl), .pc_write(pcw3), .ifid_write(ifw3),
        .idex_bubble(bub3), .fwd_a(fa3), .fwd_b(fb3), .stall_count(cnt3)
    );

    hazard_scoreboard #(.DEPTH(4), .LOAD_LAT(2), .CNTW(8)) dut4 (
        .clk(clk), .reset(rst_n), .id_valid(in4.valid),
        .id_rs1(in4.rs1), .id_rs2(in4.rs2),
        .id_use_rs1(in4.u1), .id_use_rs2(in4.u2),
        .id_rd(in4.rd), .id_regwrite(in4.rw), .id_memread(in4.mr),
        .flush(in4.fl), .pc_write(pcw4), .ifid_write(ifw4),
        .idex_bubble(bub4), .fwd_a(fa4), .fwd_b(fb4), .stall_count(cnt4)
    );

    function automatic in_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                               logic u2, logic [4:0] rd, logic rw, logic mr, logic fl);
        in_t i;
        i.valid = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        i.rd = rd; i.rw = rw; i.mr = mr; i.fl = fl;
        return i;
    endfunction

    task automatic addv(int d, in_t i, logic st, logic bub, int fa, int fb);
        vec_t t;
        t.d = d; t.in = i; t.st = st; t.bub = bub; t.fa = fa; t.fb = fb;
        vecs.push_back(t);
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t t, int idx);
        if (t.d == 0) begin in3 = t.in; in4 = '0; end
        else          begin in4 = t.in; in3 = '0; end
        #2;
        if (t.d == 0) begin
            chk($sformatf("v%0d_pc_write", idx), 32'(pcw3), 32'(!t.st));
            chk($sformatf("v%0d_ifid_write", idx), 32'(ifw3), 32'(!t.st));
            chk($sformatf("v%0d_bubble", idx), 32'(bub3), 32'(t.bub));
        end else begin
            chk($sformatf("v%0d_pc_write", idx), 32'(pcw4), 32'(!t.st));
            chk($sformatf("v%0d_ifid_write", idx), 32'(ifw4), 32'(!t.st));
            chk($sformatf("v%0d_bubble", idx), 32'(bub4), 32'(t.bub));
        end
        @(posedge clk); #1;
        if (t.d == 0) begin
            chk($sformatf("v%0d_fwd_a", idx), 32'(fa3), t.fa);
            chk($sformatf("v%0d_fwd_b", idx), 32'(fb3), t.fb);
        end else begin
            chk($sformatf("v%0d_fwd_a", idx), 32'(fa4), t.fa);
            chk($sformatf("v%0d_fwd_b", idx), 32'(fb4), t.fb);
        end
    endtask

    initial begin
        in3 = '0;
        in4 = '0;

        // DEPTH=3, LOAD_LAT=1: load-use, one stall then select 3
        addv(0, mk(1, 1, 1, 0, 0, 5, 1, 1, 0), 0, 0, 0, 0);
        addv(0, mk(1, 5, 1, 7, 1, 6, 1, 0, 0), 1, 1, 0, 0);
        addv(0, mk(1, 5, 1, 7, 1, 6, 1, 0, 0), 0, 0, 3, 0);
        // back-to-back ALU dependency
        addv(0, mk(1, 2, 1, 3, 1, 1, 1, 0, 0), 0, 0, 0, 0);
        addv(0, mk(1, 1, 1, 1, 1, 2, 1, 0, 0), 0, 0, 2, 2);
        // producer, two unrelated, consumer -> producer in WB -> select 0
        addv(0, mk(1, 0, 0, 0, 0, 9, 1, 0, 0), 0, 0, 0, 0);
        addv(0, mk(1, 0, 0, 0, 0, 10, 1, 0, 0), 0, 0, 0, 0);
        addv(0, mk(1, 0, 0, 0, 0, 11, 1, 0, 0), 0, 0, 0, 0);
        addv(0, mk(1, 9, 1, 9, 1, 12, 1, 0, 0), 0, 0, 0, 0);
        // x11 at MEM-feed (3), x10 retiring (0)
        addv(0, mk(1, 11, 1, 10, 1, 0, 0, 0, 0), 0, 0, 3, 0);
        // ld x0 then use x0
        addv(0, mk(1, 0, 0, 0, 0, 0, 1, 1, 0), 0, 0, 0, 0);
        addv(0, mk(1, 0, 1, 0, 1, 13, 1, 1, 0), 0, 0, 0, 0);
        // sources match the fresh load but are not used
        addv(0, mk(1, 13, 0, 13, 0, 0, 0, 0, 0), 0, 0, 0, 0);
        // no instruction in ID
        addv(0, mk(0, 13, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0);
        // flush while a load-use stall is pending
        addv(0, mk(1, 0, 0, 0, 0, 5, 1, 1, 0), 0, 0, 0, 0);
        addv(0, mk(1, 5, 1, 0, 0, 6, 1, 0, 1), 0, 1, 0, 0);
        addv(0, mk(1, 5, 1, 0, 0, 6, 1, 0, 0), 0, 0, 0, 0);
        // DEPTH=4, LOAD_LAT=2: two stalls, then select 4
        addv(1, mk(1, 0, 0, 0, 0, 3, 1, 1, 0), 0, 0, 0, 0);
        addv(1, mk(1, 3, 1, 3, 1, 4, 1, 0, 0), 1, 1, 0, 0);
        addv(1, mk(1, 3, 1, 3, 1, 4, 1, 0, 0), 1, 1, 0, 0);
        addv(1, mk(1, 3, 1, 3, 1, 4, 1, 0, 0), 0, 0, 4, 4);

        // reset state (asynchronous, before any clock edge)
        #1;
        chk("rst_pc_write", 32'(pcw3), 1);
        chk("rst_ifid_write", 32'(ifw3), 1);
        chk("rst_bubble_idle", 32'(bub3), 1);
        chk("rst_fwd_a", 32'(fa3), 0);
        chk("rst_fwd_b", 32'(fb3), 0);
        chk("rst_cnt3", 32'(cnt3), 0);
        chk("rst_cnt4", 32'(cnt4), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        chk("cnt3_after_table", 32'(cnt3), 1);
        chk("cnt4_after_table", 32'(cnt4), 2);

        // reset pulse in the middle of a stall
        in4 = '0;
        in3 = mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
        @(posedge clk); #1;
        in3 = mk(1, 1, 1, 0, 0, 5, 1, 1, 0);
        @(posedge clk); #1;
        chk("pre_rst_fwd_a", 32'(fa3), 2);
        in3 = mk(1, 5, 1, 0, 0, 6, 1, 0, 0);
        #2;
        chk("pre_rst_stall", 32'(pcw3), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pc_write", 32'(pcw3), 1);
        chk("midrst_ifid_write", 32'(ifw3), 1);
        chk("midrst_bubble", 32'(bub3), 0);
        chk("midrst_fwd_a", 32'(fa3), 0);
        chk("midrst_fwd_b", 32'(fb3), 0);
        chk("midrst_cnt3", 32'(cnt3), 0);
        chk("midrst_cnt4", 32'(cnt4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_no_stall", 32'(pcw3), 1);
        @(posedge clk); #1;
        chk("postrst_fwd_a", 32'(fa3), 0);

        // 9 load-use stalls on a 3-bit counter
        for (int i = 1; i <= 9; i++) begin
            in3 = mk(1, 0, 0, 0, 0, 7, 1, 1, 0);
            @(posedge clk); #1;
            in3 = mk(1, 7, 1, 0, 0, 8, 1, 0, 0);
            #2;
            chk($sformatf("sat_stall%0d", i), 32'(pcw3), 0);
            @(posedge clk); #1;
            if (i == 3) chk("sat_cnt_3", 32'(cnt3), 3);
        end
        chk("sat_cnt_final", 32'(cnt3), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
